// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM arbiter. Display fetches have strict priority;
//            CPU reads and writes use the remaining slots and are stalled
//            while a display fetch is pending or in progress. Defining
//            VRAM_ARB_STATS_EN adds the CPU stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module vram_arbiter #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        vid_fetch,
    input  logic [13:0] vid_addr,
    output logic [15:0] vid_data,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_wtbt,
    input  logic [13:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,
    output logic [13:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic [15:0] stall_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VID_RD = 3'd1,
        ST_CPU_RD = 3'd2,
        ST_CPU_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_vid_pend;
    logic [13:0] r_vid_addr_q;
    logic        r_cpu_pend;
    logic        r_cpu_req_d;
    logic        r_cpu_we_q;
    logic [1:0]  r_cpu_be_q;
    logic [13:0] r_cpu_addr_q;
    logic [15:0] r_cpu_din_q;
    logic [1:0]  r_lat_cnt;

    logic        w_cpu_rise;
    logic        w_vid_go;
    logic        w_lat_done;
    logic [13:0] w_vid_addr_eff;

    assign w_cpu_rise     = cpu_req & ~r_cpu_req_d;
    // A fetch pulse is served in the same cycle it arrives when idle, which
    // keeps the idle fetch-to-data latency at MEM_LAT+2.
    assign w_vid_go       = vid_fetch | r_vid_pend;
    assign w_vid_addr_eff = vid_fetch ? vid_addr : r_vid_addr_q;
    assign w_lat_done     = (r_lat_cnt == 2'(MEM_LAT));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_vid_pend   <= 1'b0;
            r_vid_addr_q <= 14'h0000;
            r_cpu_pend   <= 1'b0;
            r_cpu_req_d  <= 1'b0;
            r_cpu_we_q   <= 1'b0;
            r_cpu_be_q   <= 2'b00;
            r_cpu_addr_q <= 14'h0000;
            r_cpu_din_q  <= 16'h0000;
            r_lat_cnt    <= 2'd0;
            vid_data     <= 16'h0000;
            cpu_dout     <= 16'h0000;
            cpu_ack      <= 1'b0;
            mem_addr     <= 14'h0000;
            mem_rd       <= 1'b0;
            mem_we       <= 1'b0;
            mem_be       <= 2'b00;
            mem_wdata    <= 16'h0000;
        end else begin
            mem_rd      <= 1'b0;
            mem_we      <= 1'b0;
            cpu_ack     <= 1'b0;
            r_cpu_req_d <= cpu_req;

            if (w_cpu_rise) begin
                r_cpu_pend   <= 1'b1;
                r_cpu_we_q   <= cpu_we;
                r_cpu_be_q   <= (cpu_wtbt == 2'b00) ? 2'b11 : cpu_wtbt;
                r_cpu_addr_q <= cpu_addr;
                r_cpu_din_q  <= cpu_din;
            end

            // A newer fetch overwrites an unserved one.
            if (vid_fetch) begin
                r_vid_pend   <= 1'b1;
                r_vid_addr_q <= vid_addr;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_vid_go) begin
                        r_state    <= ST_VID_RD;
                        mem_rd     <= 1'b1;
                        mem_addr   <= w_vid_addr_eff;
                        r_vid_pend <= 1'b0;
                        r_lat_cnt  <= 2'd0;
                    end else if (r_cpu_pend) begin
                        mem_addr  <= r_cpu_addr_q;
                        r_lat_cnt <= 2'd0;
                        if (r_cpu_we_q) begin
                            r_state   <= ST_CPU_WR;
                            mem_we    <= 1'b1;
                            mem_be    <= r_cpu_be_q;
                            mem_wdata <= r_cpu_din_q;
                        end else begin
                            r_state <= ST_CPU_RD;
                            mem_rd  <= 1'b1;
                        end
                    end
                end
                ST_VID_RD: begin
                    if (w_lat_done) begin
                        vid_data <= mem_rdata;
                        r_state  <= ST_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                ST_CPU_RD: begin
                    if (w_lat_done) begin
                        cpu_dout   <= mem_rdata;
                        cpu_ack    <= 1'b1;
                        r_cpu_pend <= 1'b0;
                        r_state    <= ST_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 2'd1;
                    end
                end
                ST_CPU_WR: begin
                    cpu_ack    <= 1'b1;
                    r_cpu_pend <= 1'b0;
                    r_state    <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic w_stall;

    // The cycle of the request edge counts when video takes that same slot.
    assign w_stall = (r_cpu_pend | w_cpu_rise) &
                     ((r_state == ST_VID_RD) | ((r_state == ST_IDLE) & w_vid_go));

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            stall_cnt <= 16'h0000;
        end else if (w_stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed scoreboard bench for vram_arbiter with a MEM_LAT memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int LAT = 2;
`ifdef VRAM_ARB_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd4;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        vid_fetch = 1'b0;
    logic [13:0] vid_addr = '0;
    logic [15:0] vid_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_wtbt = '0;
    logic [13:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic [13:0] mem_addr;
    logic        mem_rd;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] stall_cnt;

    vram_arbiter #(.MEM_LAT(LAT)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vid_fetch(vid_fetch), .vid_addr(vid_addr), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wtbt(cpu_wtbt),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_ack(cpu_ack), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    logic rst_q = 1'b1;

    always @(posedge clk_sys) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) passed++;
        else $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    endtask

    function automatic logic [15:0] pat(input logic [13:0] a);
        return {a[7:0], ~a[7:0]} ^ {2'b00, a};
    endfunction

    // Memory model: data valid for exactly one cycle, LAT cycles after mem_rd.
    logic [15:0] mem [0:16383];
    logic [2:0]  rd_pipe = '0;
    logic [13:0] ap [0:2];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          overlap = 0;
    logic [13:0] last_waddr = '0;
    logic [1:0]  last_be = '0;
    logic [15:0] last_wdata = '0;

    assign mem_rdata = rd_pipe[LAT-1] ? mem[ap[LAT-1]] : 16'hDEAD;

    always @(posedge clk_sys) begin
        rd_pipe <= {rd_pipe[1:0], mem_rd};
        ap[0]   <= mem_addr;
        ap[1]   <= ap[0];
        ap[2]   <= ap[1];
        if (mem_rd) rd_cnt <= rd_cnt + 1;
        if (mem_we) begin
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_addr;
            last_be    <= mem_be;
            last_wdata <= mem_wdata;
            if (mem_be[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
            if (mem_be[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
        end
    end

    typedef struct {
        logic [15:0] data;
        logic        is_rd;
        int          lo;
        int          hi;
    } exp_t;

    exp_t vid_q[$];
    exp_t cpu_q[$];
    exp_t mon_e;
    logic [15:0] prev_vid = '0;

    task automatic push_vid(input logic [15:0] d, input int lo, input int hi);
        exp_t e;
        e.data = d; e.is_rd = 1'b1; e.lo = lo; e.hi = hi;
        vid_q.push_back(e);
    endtask

    task automatic push_cpu(input logic is_rd, input logic [15:0] d, input int lo, input int hi);
        exp_t e;
        e.data = d; e.is_rd = is_rd; e.lo = lo; e.hi = hi;
        cpu_q.push_back(e);
    endtask

    // Output monitor: pops the scoreboard whenever the DUT produces a result.
    always @(negedge clk_sys) begin
        if (mem_rd && mem_we) overlap = overlap + 1;
        if (rst_q) begin
            prev_vid = vid_data;
        end else begin
            if (vid_data !== prev_vid) begin
                if (vid_q.size() > 0) begin
                    mon_e = vid_q.pop_front();
                    chk("vid_data", vid_data, mon_e.data);
                    chk_rng("vid_latency", cyc, mon_e.lo, mon_e.hi);
                end else begin
                    chk("vid_unexpected_change", vid_data, prev_vid);
                end
                prev_vid = vid_data;
            end
            if (cpu_ack) begin
                if (cpu_q.size() > 0) begin
                    mon_e = cpu_q.pop_front();
                    if (mon_e.is_rd) chk("cpu_dout", cpu_dout, mon_e.data);
                    chk_rng("cpu_ack_latency", cyc, mon_e.lo, mon_e.hi);
                end else begin
                    chk("cpu_ack_unexpected", cpu_ack, 1'b0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < n && (vid_q.size() + cpu_q.size()) > 0; i++) tick();
        chk("drain_timeout", vid_q.size() + cpu_q.size(), 0);
    endtask

    task automatic cpu_start(input logic we, input logic [1:0] be, input logic [13:0] a,
                             input logic [15:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_wtbt = be; cpu_addr = a; cpu_din = d;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int acc0;
        logic [15:0] t;

        for (int i = 0; i < 16384; i++) mem[i] = pat(14'(i));
        mem[14'h1234] = 16'hA5C3;

        // Reset state
        reset = 1'b1;
        idle(3);
        @(negedge clk_sys);
        chk("reset_vid_data", vid_data, 16'h0000);
        chk("reset_cpu_dout", cpu_dout, 16'h0000);
        chk("reset_cpu_ack", cpu_ack, 1'b0);
        chk("reset_mem_bus", {mem_addr, mem_rd, mem_we, mem_be, mem_wdata}, 34'h0);
        chk("reset_stall_cnt", stall_cnt, 16'h0000);
        tick();
        reset = 1'b0;
        idle(3);

        // Video only
        c = cyc;
        vid_fetch = 1'b1; vid_addr = 14'h1234;
        push_vid(16'hA5C3, c + LAT + 2, c + LAT + 2);
        tick();
        vid_fetch = 1'b0;
        @(negedge clk_sys);
        chk("vid_issue", {mem_rd, mem_addr}, {1'b1, 14'h1234});
        wait_drain(20);
        idle(3);

        // CPU byte write, high byte only
        acc0 = wr_cnt;
        c = cyc;
        cpu_start(1'b1, 2'b10, 14'h0040, 16'hBEEF);
        push_cpu(1'b0, 16'h0000, c + 3, c + 3);
        wait_drain(20);
        chk("wr_count", wr_cnt - acc0, 1);
        chk("wr_addr", last_waddr, 14'h0040);
        chk("wr_be", last_be, 2'b10);
        chk("wr_data", last_wdata, 16'hBEEF);
        cpu_req = 1'b0;
        idle(3);

        // CPU write with wtbt=00 -> full word
        c = cyc;
        cpu_start(1'b1, 2'b00, 14'h0041, 16'h1357);
        push_cpu(1'b0, 16'h0000, c + 3, c + 3);
        wait_drain(20);
        chk("wr_be_default", last_be, 2'b11);
        cpu_req = 1'b0;
        idle(3);

        // Simultaneous video fetch and CPU read edge
        c = cyc;
        vid_fetch = 1'b1; vid_addr = 14'h0100;
        cpu_start(1'b0, 2'b00, 14'h0041, 16'h0000);
        push_vid(pat(14'h0100), c + LAT + 2, c + LAT + 2);
        push_cpu(1'b1, 16'h1357, c + 2 * LAT + 5, c + 2 * LAT + 5);
        tick();
        vid_fetch = 1'b0;
        @(negedge clk_sys);
        chk("sim_video_first", {mem_rd, mem_addr}, {1'b1, 14'h0100});
        wait_drain(30);
        chk("stall_cnt", stall_cnt, EXP_STALL);
        cpu_req = 1'b0;
        idle(3);

        // Video fetch one cycle after a CPU read issue
        c = cyc;
        t = pat(14'h0040);
        cpu_start(1'b0, 2'b00, 14'h0040, 16'h0000);
        push_cpu(1'b1, {8'hBE, t[7:0]}, c + LAT + 3, c + LAT + 3);
        idle(2);
        @(negedge clk_sys);
        chk("cpu_rd_issue", {mem_rd, mem_addr}, {1'b1, 14'h0040});
        tick();
        vid_fetch = 1'b1; vid_addr = 14'h2ABC;
        push_vid(pat(14'h2ABC), cyc + LAT + 2, cyc + 2 * LAT + 4);
        tick();
        vid_fetch = 1'b0;
        wait_drain(30);
        chk("cpu_dout_held", cpu_dout, {8'hBE, t[7:0]});
        cpu_req = 1'b0;
        idle(3);

        // cpu_req held high long after ack -> single access
        acc0 = rd_cnt + wr_cnt;
        c = cyc;
        cpu_start(1'b0, 2'b00, 14'h0200, 16'h0000);
        push_cpu(1'b1, pat(14'h0200), c + LAT + 3, c + LAT + 3);
        idle(LAT + 3 + 20);
        chk("held_req_accesses", rd_cnt + wr_cnt - acc0, 1);
        cpu_req = 1'b0;
        tick();
        c = cyc;
        cpu_start(1'b1, 2'b01, 14'h0201, 16'h7777);
        push_cpu(1'b0, 16'h0000, c + 3, c + 3);
        wait_drain(20);
        chk("rearm_accesses", rd_cnt + wr_cnt - acc0, 2);
        cpu_req = 1'b0;
        idle(3);

        // Reset in the middle of a CPU read
        cpu_start(1'b0, 2'b00, 14'h0300, 16'h0000);
        idle(3);
        reset = 1'b1;
        cpu_req = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk_sys);
        chk("rst_mid_vid_data", vid_data, 16'h0000);
        chk("rst_mid_cpu", {cpu_ack, cpu_dout}, 17'h0);
        chk("rst_mid_mem_bus", {mem_addr, mem_rd, mem_we, mem_be, mem_wdata}, 34'h0);
        acc0 = rd_cnt + wr_cnt;
        idle(8);
        chk("rst_pend_cleared", rd_cnt + wr_cnt - acc0, 0);
        c = cyc;
        vid_fetch = 1'b1; vid_addr = 14'h0555;
        push_vid(pat(14'h0555), c + LAT + 2, c + LAT + 2);
        tick();
        vid_fetch = 1'b0;
        wait_drain(20);
        idle(3);

        chk("rd_we_overlap", overlap, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
